// File: rtl/branch_resolve_queue_if.sv
// branch_resolve_queue_if: IF allocation, MEM resolution and predictor-update/redirect signals
interface branch_resolve_queue_if #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 6,
  parameter int PC_W  = 32
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic             alloc_valid_i;
  logic             alloc_ready_o;
  logic [IDX_W-1:0] alloc_pht_idx_i;
  logic             alloc_pred_taken_i;
  logic             resolve_valid_i;
  logic             resolve_taken_i;
  logic [PC_W-1:0]  resolve_target_i;
  logic [PC_W-1:0]  resolve_pc_plus4_i;
  logic             flush_i;
  logic             branch_result_valid_o;
  logic             branch_taken_o;
  logic [IDX_W-1:0] mem_pht_idx_o;
  logic             mispredict_o;
  logic [PC_W-1:0]  redirect_pc_o;
  logic [CW-1:0]    count_o;
  logic             underflow_o;
  modport master (
    output alloc_valid_i, alloc_pht_idx_i, alloc_pred_taken_i, resolve_valid_i,
           resolve_taken_i, resolve_target_i, resolve_pc_plus4_i, flush_i,
    input  alloc_ready_o, branch_result_valid_o, branch_taken_o, mem_pht_idx_o,
           mispredict_o, redirect_pc_o, count_o, underflow_o
  );
  modport slave (
    input  alloc_valid_i, alloc_pht_idx_i, alloc_pred_taken_i, resolve_valid_i,
           resolve_taken_i, resolve_target_i, resolve_pc_plus4_i, flush_i,
    output alloc_ready_o, branch_result_valid_o, branch_taken_o, mem_pht_idx_o,
           mispredict_o, redirect_pc_o, count_o, underflow_o
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order gshare prediction tracker with predictor update and mispredict redirect
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 6,
  parameter int PC_W  = 32
) (
  input logic clk_i,
  input logic rst_ni,
  branch_resolve_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [IDX_W-1:0] idx_q [DEPTH];
  logic [DEPTH-1:0] pred_q;
  logic [PW-1:0]    rd_q, wr_q;
  logic [CW-1:0]    cnt_q;
  logic             alloc_fire, res_fire, mis, kill;
  assign bus.alloc_ready_o = cnt_q < CW'(DEPTH);
  assign bus.count_o       = cnt_q;
  assign alloc_fire        = bus.alloc_valid_i & bus.alloc_ready_o;
  assign res_fire          = bus.resolve_valid_i & (cnt_q != '0);
  assign mis               = res_fire & (bus.resolve_taken_i != pred_q[rd_q]);
  // a mispredict squashes younger entries exactly like an external flush
  assign kill              = bus.flush_i | mis;
  always_ff @(posedge clk_i) begin
    if (alloc_fire & ~kill) begin
      idx_q[wr_q]  <= bus.alloc_pht_idx_i;
      pred_q[wr_q] <= bus.alloc_pred_taken_i;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_q                      <= '0;
      wr_q                      <= '0;
      cnt_q                     <= '0;
      bus.branch_result_valid_o <= 1'b0;
      bus.branch_taken_o        <= 1'b0;
      bus.mem_pht_idx_o         <= '0;
      bus.mispredict_o          <= 1'b0;
      bus.redirect_pc_o         <= '0;
      bus.underflow_o           <= 1'b0;
    end else begin
      bus.branch_result_valid_o <= res_fire;
      bus.mispredict_o          <= mis;
      bus.underflow_o           <= bus.underflow_o | (bus.resolve_valid_i & (cnt_q == '0));
      if (res_fire) begin
        bus.branch_taken_o <= bus.resolve_taken_i;
        bus.mem_pht_idx_o  <= idx_q[rd_q];
      end
      if (mis) bus.redirect_pc_o <= bus.resolve_taken_i ? bus.resolve_target_i : bus.resolve_pc_plus4_i;
      if (kill) begin
        rd_q  <= wr_q;
        cnt_q <= '0;
      end else begin
        wr_q  <= wr_q + PW'(alloc_fire);
        rd_q  <= rd_q + PW'(res_fire);
        cnt_q <= cnt_q + CW'(alloc_fire) - CW'(res_fire);
      end
    end
  end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: scoreboard bench for branch_resolve_queue
module tb_branch_resolve_queue;
  localparam int DEPTH = 4;
  typedef struct packed {logic [5:0] idx; logic pred;} ent_t;
  typedef struct packed {logic taken; logic [5:0] idx; logic mis; logic [31:0] pc;} exp_t;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int   vec = 0;
  int   err = 0;
  ent_t mq[$];
  exp_t sb[$];
  exp_t e;
  logic        munder = 1'b0;
  logic [31:0] last_pc = '0;
  branch_resolve_queue_if #(.DEPTH(DEPTH), .IDX_W(6), .PC_W(32)) bus ();
  branch_resolve_queue #(.DEPTH(DEPTH), .IDX_W(6), .PC_W(32)) dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alloc_valid_i      = 1'b0;
    bus.alloc_pht_idx_i    = '0;
    bus.alloc_pred_taken_i = 1'b0;
    bus.resolve_valid_i    = 1'b0;
    bus.resolve_taken_i    = 1'b0;
    bus.resolve_target_i   = '0;
    bus.resolve_pc_plus4_i = '0;
    bus.flush_i            = 1'b0;
  endtask

  // drives one cycle and advances the reference model, pushing expected updates
  task automatic drive(input logic av, input logic [5:0] idx, input logic pt, input logic rv,
                       input logic rt, input logic [31:0] tgt, input logic [31:0] p4, input logic fl);
    logic af, rf, m;
    ent_t h;
    bus.alloc_valid_i      = av;
    bus.alloc_pht_idx_i    = idx;
    bus.alloc_pred_taken_i = pt;
    bus.resolve_valid_i    = rv;
    bus.resolve_taken_i    = rt;
    bus.resolve_target_i   = tgt;
    bus.resolve_pc_plus4_i = p4;
    bus.flush_i            = fl;
    af = av && (mq.size() < DEPTH);
    rf = rv && (mq.size() > 0);
    m  = 1'b0;
    if (rv && mq.size() == 0) munder = 1'b1;
    if (rf) begin
      h = mq[0];
      m = (rt != h.pred);
      if (m) last_pc = rt ? tgt : p4;
      sb.push_back('{taken: rt, idx: h.idx, mis: m, pc: last_pc});
    end
    if (fl || m) mq.delete();
    else begin
      if (rf) void'(mq.pop_front());
      if (af) mq.push_back('{idx: idx, pred: pt});
    end
    tick();
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    mq.delete();
    sb.delete();
    munder  = 1'b0;
    last_pc = '0;
  endtask

  task automatic test_reset();
    do_reset();
    vec++;
    if ({bus.count_o, bus.alloc_ready_o, bus.branch_result_valid_o, bus.mispredict_o, bus.underflow_o,
         bus.redirect_pc_o, bus.mem_pht_idx_o, bus.branch_taken_o} !== {3'd0, 1'b1, 3'b000, 32'h0, 6'h0, 1'b0}) begin
      err++;
      $display("FAIL reset: count=%0d ready=%b v=%b mis=%b uf=%b pc=%h idx=%h tk=%b", bus.count_o, bus.alloc_ready_o,
               bus.branch_result_valid_o, bus.mispredict_o, bus.underflow_o, bus.redirect_pc_o, bus.mem_pht_idx_o, bus.branch_taken_o);
    end
  endtask

  task automatic test_fill();
    logic [5:0] ids [4] = '{6'h05, 6'h0A, 6'h11, 6'h3F};
    for (int i = 0; i < 4; i++) drive(1'b1, ids[i], 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    vec++;
    if ({bus.count_o, bus.alloc_ready_o} !== {3'd4, 1'b0}) begin
      err++;
      $display("FAIL fill: count=%0d ready=%b, want 4/0", bus.count_o, bus.alloc_ready_o);
    end
    drive(1'b1, 6'h22, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    vec++;
    if (bus.count_o !== 3'd4) begin
      err++;
      $display("FAIL full_reject: count=%0d want 4", bus.count_o);
    end
  endtask

  task automatic test_resolve_correct();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 32'h40, 32'h44, 1'b0);
    e = sb.pop_front();
    vec++;
    if ({bus.branch_result_valid_o, bus.branch_taken_o, bus.mem_pht_idx_o, bus.mispredict_o, bus.count_o}
        !== {1'b1, e.taken, e.idx, e.mis, 3'd3} || e.idx !== 6'h05) begin
      err++;
      $display("FAIL resolve_correct: v=%b tk=%b idx=%h mis=%b count=%0d want 1/%b/%h/%b/3", bus.branch_result_valid_o,
               bus.branch_taken_o, bus.mem_pht_idx_o, bus.mispredict_o, bus.count_o, e.taken, e.idx, e.mis);
    end
    tick();
    vec++;
    if ({bus.branch_result_valid_o, bus.mispredict_o} !== 2'b00) begin
      err++;
      $display("FAIL strobe_pulse: v=%b mis=%b want 0/0", bus.branch_result_valid_o, bus.mispredict_o);
    end
  endtask

  task automatic test_mispredict_taken();
    do_reset();
    drive(1'b1, 6'h12, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 6'h13, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 6'h14, 1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0050, 1'b0);
    e = sb.pop_front();
    vec++;
    if ({bus.branch_result_valid_o, bus.mispredict_o, bus.redirect_pc_o, bus.mem_pht_idx_o, bus.count_o}
        !== {1'b1, e.mis, e.pc, e.idx, 3'd0} || e.pc !== 32'h100) begin
      err++;
      $display("FAIL mispredict_taken: v=%b mis=%b pc=%h idx=%h count=%0d want 1/%b/%h/%h/0", bus.branch_result_valid_o,
               bus.mispredict_o, bus.redirect_pc_o, bus.mem_pht_idx_o, bus.count_o, e.mis, e.pc, e.idx);
    end
    tick();
    vec++;
    if ({bus.mispredict_o, bus.redirect_pc_o, bus.count_o} !== {1'b0, 32'h100, 3'd0}) begin
      err++;
      $display("FAIL redirect_hold: mis=%b pc=%h count=%0d want 0/00000100/0", bus.mispredict_o, bus.redirect_pc_o, bus.count_o);
    end
  endtask

  task automatic test_mispredict_not_taken();
    drive(1'b1, 6'h2A, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 6'h2B, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 32'h0000_0999, 32'h0000_0208, 1'b0);
    e = sb.pop_front();
    vec++;
    if ({bus.branch_result_valid_o, bus.branch_taken_o, bus.mispredict_o, bus.redirect_pc_o, bus.mem_pht_idx_o, bus.count_o}
        !== {1'b1, 1'b0, 1'b1, 32'h208, 6'h2A, 3'd0} || e.pc !== 32'h208) begin
      err++;
      $display("FAIL mispredict_not_taken: v=%b tk=%b mis=%b pc=%h idx=%h count=%0d want 1/0/1/00000208/2a/0",
               bus.branch_result_valid_o, bus.branch_taken_o, bus.mispredict_o, bus.redirect_pc_o, bus.mem_pht_idx_o, bus.count_o);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 32'h10, 32'h14, 1'b0);
    vec++;
    if ({bus.branch_result_valid_o, bus.mispredict_o, bus.underflow_o, bus.count_o} !== {1'b0, 1'b0, munder, 3'd0}) begin
      err++;
      $display("FAIL underflow_set: v=%b mis=%b uf=%b count=%0d want 0/0/1/0", bus.branch_result_valid_o,
               bus.mispredict_o, bus.underflow_o, bus.count_o);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      vec++;
      if (bus.underflow_o !== 1'b1) begin
        err++;
        $display("FAIL underflow_sticky[%0d]: uf=%b want 1", i, bus.underflow_o);
      end
    end
    do_reset();
    vec++;
    if (bus.underflow_o !== 1'b0) begin
      err++;
      $display("FAIL underflow_clear: uf=%b want 0", bus.underflow_o);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b1, 6'h01, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 6'h02, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 6'h03, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 6'h04, 1'b0, 1'b1, 1'b1, 32'h200, 32'h204, 1'b0);
    e = sb.pop_front();
    vec++;
    if ({bus.branch_result_valid_o, bus.mem_pht_idx_o, bus.mispredict_o, bus.count_o} !== {1'b1, e.idx, e.mis, 3'd3}
        || e.idx !== 6'h01) begin
      err++;
      $display("FAIL alloc_and_resolve: v=%b idx=%h mis=%b count=%0d want 1/01/0/3", bus.branch_result_valid_o,
               bus.mem_pht_idx_o, bus.mispredict_o, bus.count_o);
    end
    drive(1'b1, 6'h05, 1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
    vec++;
    if ({bus.count_o, bus.alloc_ready_o, bus.branch_result_valid_o} !== {3'd0, 1'b1, 1'b0}) begin
      err++;
      $display("FAIL flush_alloc: count=%0d ready=%b v=%b want 0/1/0", bus.count_o, bus.alloc_ready_o, bus.branch_result_valid_o);
    end
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
    vec++;
    if ({bus.underflow_o, bus.branch_result_valid_o} !== {1'b1, 1'b0}) begin
      err++;
      $display("FAIL flush_then_underflow: uf=%b v=%b want 1/0", bus.underflow_o, bus.branch_result_valid_o);
    end
  endtask

  task automatic test_flush_with_resolve();
    do_reset();
    drive(1'b1, 6'h31, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 6'h32, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 32'h300, 32'h304, 1'b1);
    e = sb.pop_front();
    vec++;
    if ({bus.branch_result_valid_o, bus.branch_taken_o, bus.mem_pht_idx_o, bus.mispredict_o, bus.count_o}
        !== {1'b1, 1'b1, 6'h31, 1'b0, 3'd0} || e.mis !== 1'b0) begin
      err++;
      $display("FAIL flush_resolve: v=%b tk=%b idx=%h mis=%b count=%0d want 1/1/31/0/0", bus.branch_result_valid_o,
               bus.branch_taken_o, bus.mem_pht_idx_o, bus.mispredict_o, bus.count_o);
    end
  endtask

  task automatic test_random();
    logic av, pt, rv, rt, fl;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      av = 1'($urandom_range(0, 1));
      pt = 1'($urandom_range(0, 3) != 0);
      rv = 1'($urandom_range(0, 2) == 0);
      rt = 1'($urandom_range(0, 3) != 0);
      fl = 1'($urandom_range(0, 29) == 0);
      drive(av, 6'($urandom), pt, rv, rt, $urandom, $urandom, fl);
      vec++;
      if ({bus.count_o, bus.alloc_ready_o, bus.underflow_o} !== {3'(mq.size()), mq.size() < DEPTH, munder}) begin
        err++;
        $display("FAIL rand_state[%0d]: count=%0d ready=%b uf=%b want %0d/%b/%b", i, bus.count_o, bus.alloc_ready_o,
                 bus.underflow_o, mq.size(), mq.size() < DEPTH, munder);
      end
      vec++;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (bus.branch_result_valid_o !== 1'b1 ||
            {bus.branch_taken_o, bus.mem_pht_idx_o, bus.mispredict_o, bus.redirect_pc_o} !== e) begin
          err++;
          $display("FAIL rand_update[%0d]: v=%b tk=%b idx=%h mis=%b pc=%h want 1/%b/%h/%b/%h", i, bus.branch_result_valid_o,
                   bus.branch_taken_o, bus.mem_pht_idx_o, bus.mispredict_o, bus.redirect_pc_o, e.taken, e.idx, e.mis, e.pc);
        end
      end else if ({bus.branch_result_valid_o, bus.mispredict_o, bus.redirect_pc_o} !== {2'b00, last_pc}) begin
        err++;
        $display("FAIL rand_idle[%0d]: v=%b mis=%b pc=%h want 0/0/%h", i, bus.branch_result_valid_o,
                 bus.mispredict_o, bus.redirect_pc_o, last_pc);
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fill();
    test_resolve_correct();
    test_mispredict_taken();
    test_mispredict_not_taken();
    test_underflow();
    test_back_to_back();
    test_flush_with_resolve();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
